evg_event_arbiter: RTL and testbench
====================================

// Module: evg_event_arbiter
// PURPOSE
//  Shares the single EVG transmit event slot between NREQ event-request streams
//  (software trigger, sequencer, hardware inputs, ...) on the evgTxClk domain.
//  Each cycle it selects at most one pending request by round-robin arbitration
//  and places it in a one-entry output register feeding the event transmitter.
//  Per-requester grant counters are provided for diagnostics.
// PARAMETERS
//  NREQ            4   number of requesters, 2..8
//  EVENTCODE_WIDTH 8   event code width
//  COUNT_WIDTH     16  width of each per-requester grant counter
//  PRIO0           1   1: requester 0 has fixed top priority; 0: all requesters round-robin
// PORTS
//  evgTxClk     in   1                    transmitter clock; the only clock
//  evgTxRst_n   in   1                    reset, synchronous, active-low
//  reqTDATA     in   NREQ*EVENTCODE_WIDTH requester i code at [i*EW +: EW]
//  reqTVALID    in   NREQ                 requester i has an event pending
//  reqTREADY    out  NREQ                 one-hot grant; at most one bit high per cycle
//  evTDATA      out  EVENTCODE_WIDTH      event code to transmitter
//  evTVALID     out  1                    evTDATA valid
//  evTREADY     in   1                    transmitter accepts evTDATA
//  countClear   in   1                    clear all grant counters
//  countSelect  in   clog2(NREQ)          counter selected for readback
//  countValue   out  COUNT_WIDTH          registered value of selected counter
// BEHAVIOUR
//  Reset (evgTxRst_n=0 at a clock edge): evTVALID=0, evTDATA=0, round-robin pointer=0,
//   all counters=0, countValue=0. reqTREADY is forced to 0 while evgTxRst_n=0.
//   Reset mid-transfer discards any event held in the output register.
//  Slot free: free = !evTVALID || evTREADY.
//  Grant (combinational): if free, choose a winner among set reqTVALID bits and
//   drive reqTREADY[winner]=1; no grant when !free or no valid request.
//   reqTREADY may depend on reqTVALID; requesters must hold TDATA/TVALID until accepted.
//  Selection: if PRIO0=1 and reqTVALID[0]=1, requester 0 wins. Otherwise scan
//   from pointer ptr upward, modulo NREQ, over round-robin-eligible requesters
//   (1..NREQ-1 if PRIO0=1, else 0..NREQ-1); the first set bit wins.
//   After a round-robin grant to k, ptr <= next eligible index after k (wraps,
//   e.g. NREQ-1 -> first eligible). Requester-0 priority grants leave ptr unchanged.
//  Output register: on a grant with nonzero code, evTDATA <= code and evTVALID <= 1
//   at the next edge (1-cycle latency, request edge N -> output valid N+1).
//   If evTREADY=1 in that same cycle, the old event retires and the new event
//   loads, giving full throughput of one event per cycle. If evTREADY=1 with no
//   grant, evTVALID <= 0 and evTDATA holds its value.
//  Null code: a granted request with code 0 is consumed (TREADY pulses) but not
//   loaded; evTVALID follows the no-grant rule and the counter is not incremented.
//  Counters: cnt[k] increments on each nonzero grant to k and saturates at
//   2^COUNT_WIDTH-1. countClear=1 zeroes all counters and takes precedence
//   over a simultaneous increment.
//   countValue <= cnt[countSelect] each cycle (1-cycle latency; pre-update value).
//   countSelect >= NREQ reads 0.
//  evTVALID never drops without evTREADY, and evTDATA is stable while evTVALID=1 && !evTREADY.
// TESTING
//  1 Reset: hold evgTxRst_n=0 with all reqTVALID=1 -> reqTREADY=0, evTVALID=0,
//    countValue=0. Release reset -> first grant on the next cycle.
//  2 Round-robin, PRIO0=0, NREQ=4, all valid, codes 0x11/0x22/0x33/0x44, evTREADY=1
//    -> evTDATA sequence 11,22,33,44,11,... one per cycle; each counter=2 after 8 grants.
//  3 PRIO0=1, req0 valid for 3 cycles, req2/req3 always valid -> three 0x11 outputs,
//    then 0x33, 0x44, 0x33. ptr is unaffected by the req0 grants.
//  4 Backpressure: evTREADY=0 for 5 cycles with req1 valid (0x22) -> evTVALID=1,
//    evTDATA=0x22 stable, reqTREADY=0. evTREADY=1 -> next grant in the same cycle, no gap.
//  5 Null code: req1 presents 0x00 -> reqTREADY[1] pulses, evTVALID stays 0, cnt[1] unchanged.
//  6 Counters: COUNT_WIDTH=4, 20 grants to req2 -> countValue=15 (saturated).
//    countClear coincident with a grant -> countValue=0 one cycle later.

Source files
------------

// File: rtl/evg_event_arbiter.sv
// evg_event_arbiter
//   Shares the single EVG transmit event slot between NREQ event-request
//   streams on the evgTxClk domain. Each cycle at most one pending request is
//   picked (optional fixed priority for requester 0, round-robin for the rest)
//   and its code is loaded into a one-entry output register that feeds the
//   event transmitter. Per-requester saturating grant counters are kept for
//   diagnostics and read back through a registered select port.
//
// Ports
//   evgTxClk     transmitter clock, the only clock
//   evgTxRst_n   synchronous active-low reset
//   reqTDATA     requester i event code at [i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH]
//   reqTVALID    requester i has an event pending
//   reqTREADY    one-hot grant (combinational), low during reset
//   evTDATA      event code to the transmitter
//   evTVALID     evTDATA holds a valid event
//   evTREADY     transmitter accepts evTDATA
//   countClear   zero all grant counters
//   countSelect  grant counter chosen for readback
//   countValue   registered value of the chosen counter
module evg_event_arbiter #(
  parameter int NREQ            = 4,
  parameter int EVENTCODE_WIDTH = 8,
  parameter int COUNT_WIDTH     = 16,
  parameter int PRIO0           = 1
) (
  input  logic                            evgTxClk,
  input  logic                            evgTxRst_n,
  input  logic [NREQ*EVENTCODE_WIDTH-1:0] reqTDATA,
  input  logic [NREQ-1:0]                 reqTVALID,
  output logic [NREQ-1:0]                 reqTREADY,
  output logic [EVENTCODE_WIDTH-1:0]      evTDATA,
  output logic                            evTVALID,
  input  logic                            evTREADY,
  input  logic                            countClear,
  input  logic [$clog2(NREQ)-1:0]         countSelect,
  output logic [COUNT_WIDTH-1:0]          countValue
);

  localparam int IW = $clog2(NREQ);
  localparam int EW = EVENTCODE_WIDTH;
  localparam bit PRIO_EN = (PRIO0 != 0);
  // Requesters that take part in the round-robin scan
  localparam logic [NREQ-1:0] RR_MASK = PRIO_EN ? {{(NREQ-1){1'b1}}, 1'b0} : {NREQ{1'b1}};
  // Where the pointer wraps to after the last requester
  localparam logic [IW-1:0] FIRST_RR = PRIO_EN ? IW'(1) : IW'(0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [IW-1:0]          ptr;
  logic [IW-1:0]          nextPtr;
  logic [NREQ-1:0]        rrCand;
  logic [IW:0]            rrSum;
  logic                   rrFound;
  logic [IW-1:0]          rrWinner;
  logic                   prioWin;
  logic                   slotFree;
  logic                   grantValid;
  logic [IW-1:0]          winner;
  logic [EW-1:0]          grantCode;
  logic                   loadEvent;
  logic [COUNT_WIDTH-1:0] cnt [NREQ];
  logic [COUNT_WIDTH-1:0] selCount;

  assign slotFree = !evTVALID || evTREADY;
  assign rrCand   = reqTVALID & RR_MASK;
  assign prioWin  = PRIO_EN && reqTVALID[0];

  // Round-robin scan starting at ptr; the sum is one bit wider than the
  // index so the modulo-NREQ wrap is a single conditional subtract.
  always_comb begin
    rrFound  = 1'b0;
    rrWinner = '0;
    rrSum    = '0;
    for (int i = 0; i < NREQ; i++) begin
      rrSum = {1'b0, ptr} + (IW+1)'(i);
      if (rrSum >= (IW+1)'(NREQ)) begin
        rrSum = rrSum - (IW+1)'(NREQ);
      end
      if (!rrFound && rrCand[rrSum[IW-1:0]]) begin
        rrFound  = 1'b1;
        rrWinner = rrSum[IW-1:0];
      end
    end
  end

  // Winner selection, grant decode and the code of the granted request.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    grantValid = evgTxRst_n && slotFree && (prioWin || rrFound);
    winner     = prioWin ? '0 : rrWinner;
    nextPtr    = (rrWinner == IW'(NREQ-1)) ? FIRST_RR : rrWinner + IW'(1);
    grantCode  = '0;
    reqTREADY  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner == IW'(k)) begin
        grantCode    = reqTDATA[k*EW +: EW];
        reqTREADY[k] = grantValid;
      end
    end
    // A zero code is consumed from the requester but never transmitted
    loadEvent = grantValid && (grantCode != '0);
  end

  // Output register and round-robin pointer. A new event may load in the
  // same cycle the old one retires; otherwise a retiring event clears
  // evTVALID while leaving evTDATA untouched. Priority grants to requester 0
  // do not move the pointer, null-code round-robin grants do.
  always_ff @(posedge evgTxClk) begin
    if (!evgTxRst_n) begin
      evTVALID <= 1'b0;
      evTDATA  <= '0;
      ptr      <= '0;
    end else begin
      if (loadEvent) begin
        evTDATA  <= grantCode;
        evTVALID <= 1'b1;
      end else if (evTREADY) begin
        evTVALID <= 1'b0;
      end
      if (grantValid && !prioWin) begin
        ptr <= nextPtr;
      end
    end
  end

  // Saturating grant counters; clear wins over a coincident increment
  always_ff @(posedge evgTxClk) begin
    if (!evgTxRst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (countClear) begin
          cnt[k] <= '0;
        end else if (loadEvent && (winner == IW'(k)) && (cnt[k] != COUNT_MAX)) begin
          cnt[k] <= cnt[k] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Readback mux; selects beyond the last requester read as zero
  always_comb begin
    selCount = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (countSelect == IW'(k)) begin
        selCount = cnt[k];
      end
    end
  end

  // Registered readback of the counter value before this edge's update
  always_ff @(posedge evgTxClk) begin
    if (!evgTxRst_n) begin
      countValue <= '0;
    end else begin
      countValue <= selCount;
    end
  end

endmodule

// File: tb/tb_evg_event_arbiter.sv
// tb_evg_event_arbiter
//   Directed bench for evg_event_arbiter. Two instances share one set of
//   stimulus: dutRr runs pure round-robin, dutPrio gives requester 0 fixed
//   priority. Both use 4 requesters, 8-bit codes and 4-bit counters so that
//   saturation is reachable in a handful of cycles.
module tb_evg_event_arbiter;

  logic        evgTxClk;
  logic        evgTxRst_n;
  logic [31:0] reqTDATA;
  logic [3:0]  reqTVALID;
  logic        evTREADY;
  logic        countClear;
  logic [1:0]  countSelect;

  logic [3:0]  rrReqTREADY;
  logic [7:0]  rrEvTDATA;
  logic        rrEvTVALID;
  logic [3:0]  rrCountValue;

  logic [3:0]  prReqTREADY;
  logic [7:0]  prEvTDATA;
  logic        prEvTVALID;
  logic [3:0]  prCountValue;

  int checks = 0;
  int errors = 0;

  logic [31:0] codes = 32'h44332211;
  logic [7:0]  prioExpect [6];

  evg_event_arbiter #(
    .NREQ(4), .EVENTCODE_WIDTH(8), .COUNT_WIDTH(4), .PRIO0(0)
  ) dutRr (
    .evgTxClk(evgTxClk), .evgTxRst_n(evgTxRst_n),
    .reqTDATA(reqTDATA), .reqTVALID(reqTVALID), .reqTREADY(rrReqTREADY),
    .evTDATA(rrEvTDATA), .evTVALID(rrEvTVALID), .evTREADY(evTREADY),
    .countClear(countClear), .countSelect(countSelect), .countValue(rrCountValue)
  );

  evg_event_arbiter #(
    .NREQ(4), .EVENTCODE_WIDTH(8), .COUNT_WIDTH(4), .PRIO0(1)
  ) dutPrio (
    .evgTxClk(evgTxClk), .evgTxRst_n(evgTxRst_n),
    .reqTDATA(reqTDATA), .reqTVALID(reqTVALID), .reqTREADY(prReqTREADY),
    .evTDATA(prEvTDATA), .evTVALID(prEvTVALID), .evTREADY(evTREADY),
    .countClear(countClear), .countSelect(countSelect), .countValue(prCountValue)
  );

  // 10-unit transmitter clock
  initial begin
    evgTxClk = 1'b0;
    forever #5 evgTxClk = ~evgTxClk;
  end

  // Drive the request-side and transmitter-side inputs together
  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic ready);
    reqTVALID = valid;
    reqTDATA  = data;
    evTREADY  = ready;
  endtask

  // Advance to just after the next rising edge
  task automatic nextCycle();
    @(posedge evgTxClk);
    #1;
  endtask

  // One comparison: counts it, and on a miss counts and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    prioExpect[0] = 8'h11; prioExpect[1] = 8'h11; prioExpect[2] = 8'h11;
    prioExpect[3] = 8'h33; prioExpect[4] = 8'h44; prioExpect[5] = 8'h33;

    // Reset held with every requester asking
    evgTxRst_n  = 1'b0;
    countClear  = 1'b0;
    countSelect = 2'd0;
    applyStimulus(4'hF, codes, 1'b1);
    nextCycle();
    nextCycle();
    $display("[TB] reset");
    checkOutput("rst_rr_tready", 32'(rrReqTREADY), 32'h0);
    checkOutput("rst_rr_tvalid", 32'(rrEvTVALID), 32'h0);
    checkOutput("rst_rr_count", 32'(rrCountValue), 32'h0);
    checkOutput("rst_pr_tready", 32'(prReqTREADY), 32'h0);
    checkOutput("rst_pr_tvalid", 32'(prEvTVALID), 32'h0);
    checkOutput("rst_pr_tdata", 32'(prEvTDATA), 32'h0);

    // Round-robin over four always-valid requesters
    $display("[TB] round-robin");
    evgTxRst_n = 1'b1;
    #1;
    checkOutput("rr_first_grant", 32'(rrReqTREADY), 32'h1);
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      checkOutput("rr_tvalid", 32'(rrEvTVALID), 32'h1);
      checkOutput("rr_tdata", 32'(rrEvTDATA), 32'(codes[(i % 4) * 8 +: 8]));
      if (i < 7) begin
        checkOutput("rr_grant", 32'(rrReqTREADY), 32'(4'b0001 << ((i + 1) % 4)));
      end
    end
    reqTVALID = 4'h0;
    for (int k = 0; k < 4; k++) begin
      countSelect = 2'(k);
      nextCycle();
      checkOutput("rr_count", 32'(rrCountValue), 32'd2);
    end

    // Priority requester 0 for three cycles, then round-robin over 2 and 3
    $display("[TB] priority");
    evgTxRst_n = 1'b0;
    applyStimulus(4'h0, codes, 1'b1);
    nextCycle();
    evgTxRst_n = 1'b1;
    applyStimulus(4'b1101, codes, 1'b1);
    #1;
    checkOutput("pr_first_grant", 32'(prReqTREADY), 32'h1);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        reqTVALID = 4'b1100;
      end
      nextCycle();
      checkOutput("pr_tvalid", 32'(prEvTVALID), 32'h1);
      checkOutput("pr_tdata", 32'(prEvTDATA), 32'(prioExpect[i]));
    end

    // Reset discards held events; then backpressure on a single requester
    $display("[TB] backpressure");
    evgTxRst_n = 1'b0;
    applyStimulus(4'h0, codes, 1'b0);
    nextCycle();
    checkOutput("rst_discard_tvalid", 32'(prEvTVALID), 32'h0);
    checkOutput("rst_discard_tdata", 32'(prEvTDATA), 32'h0);
    evgTxRst_n = 1'b1;
    applyStimulus(4'b0010, codes, 1'b0);
    #1;
    checkOutput("bp_first_grant", 32'(rrReqTREADY), 32'h2);
    nextCycle();
    checkOutput("bp_load_tvalid", 32'(rrEvTVALID), 32'h1);
    checkOutput("bp_load_tdata", 32'(rrEvTDATA), 32'h22);
    reqTDATA = 32'h44335511;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("bp_hold_tvalid", 32'(rrEvTVALID), 32'h1);
      checkOutput("bp_hold_tdata", 32'(rrEvTDATA), 32'h22);
      checkOutput("bp_hold_tready", 32'(rrReqTREADY), 32'h0);
    end
    evTREADY = 1'b1;
    #1;
    checkOutput("bp_release_grant", 32'(rrReqTREADY), 32'h2);
    nextCycle();
    checkOutput("bp_next_tvalid", 32'(rrEvTVALID), 32'h1);
    checkOutput("bp_next_tdata", 32'(rrEvTDATA), 32'h55);
    reqTVALID = 4'h0;
    nextCycle();
    checkOutput("bp_drain_tvalid", 32'(rrEvTVALID), 32'h0);
    checkOutput("bp_drain_tdata", 32'(rrEvTDATA), 32'h55);

    // Null code from requester 1: consumed, not transmitted, not counted
    $display("[TB] null code");
    countSelect = 2'd1;
    applyStimulus(4'b0010, 32'h44330011, 1'b1);
    #1;
    checkOutput("null_grant", 32'(rrReqTREADY), 32'h2);
    nextCycle();
    checkOutput("null_tvalid", 32'(rrEvTVALID), 32'h0);
    checkOutput("null_count_before", 32'(rrCountValue), 32'd2);
    reqTVALID = 4'h0;
    nextCycle();
    checkOutput("null_count_after", 32'(rrCountValue), 32'd2);

    // Counter saturation and clear-over-increment precedence
    $display("[TB] counters");
    evgTxRst_n = 1'b0;
    applyStimulus(4'h0, codes, 1'b1);
    nextCycle();
    evgTxRst_n  = 1'b1;
    countSelect = 2'd2;
    applyStimulus(4'b0100, codes, 1'b1);
    for (int i = 0; i < 20; i++) begin
      nextCycle();
    end
    checkOutput("cnt_saturated", 32'(rrCountValue), 32'd15);
    countClear = 1'b1;
    nextCycle();
    checkOutput("cnt_clear_edge", 32'(rrCountValue), 32'd15);
    countClear = 1'b0;
    nextCycle();
    checkOutput("cnt_cleared", 32'(rrCountValue), 32'd0);
    reqTVALID = 4'h0;
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
